// File: rtl/rd_ptr_empty_gen.sv
// Read-domain pointer and flag generator for an async FIFO: advances the read pointer,
// derives registered empty/almost-empty flags. Optional macro RD_LEVEL_EN adds a rd_level output.
module rd_ptr_empty_gen #(
  parameter int ADDR_W       = 4,
  parameter int ALM_EMPTY_TH = 2
) (
  input  logic              clk_r,
  input  logic              rst_r,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wr_ptr_gray_s,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              empty,
  output logic              alm_empty,
  output logic              rd_valid,
  output logic              underflow,
  output logic              wrap_B_delay
`ifdef RD_LEVEL_EN
  ,
  output logic [ADDR_W:0]   rd_level
`endif
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ALM_TH  = (ADDR_W+1)'(ALM_EMPTY_TH);

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [ADDR_W:0] r_rd_ptr_bin;
  logic            w_accept;
  logic [ADDR_W:0] w_rd_bin_next;
  logic [ADDR_W:0] w_rd_gray_next;
  logic [ADDR_W:0] w_wr_bin_s;
  logic [ADDR_W:0] w_occ_next;
  logic            w_wrap_B;

  // Combinational next-state: accept gates on the registered empty flag, so a
  // stale (older) write pointer can only make empty more pessimistic.
  always_comb begin
    w_accept       = rd_en & ~empty;
    w_rd_bin_next  = w_accept ? (r_rd_ptr_bin + PTR_ONE) : r_rd_ptr_bin;
    w_rd_gray_next = bin2gray(w_rd_bin_next);
    w_wr_bin_s     = gray2bin(wr_ptr_gray_s);
    w_occ_next     = w_wr_bin_s - w_rd_bin_next;
    w_wrap_B       = w_accept & (r_rd_ptr_bin[ADDR_W-1:0] == '1);
  end

  assign rd_addr = r_rd_ptr_bin[ADDR_W-1:0];

  // Registered pointer and flags
  always_ff @(posedge clk_r) begin
    if (rst_r) begin
      r_rd_ptr_bin <= '0;
      rd_ptr_gray  <= '0;
      empty        <= 1'b1;
      alm_empty    <= 1'b1;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
      wrap_B_delay <= 1'b0;
    end else begin
      r_rd_ptr_bin <= w_rd_bin_next;
      rd_ptr_gray  <= w_rd_gray_next;
      empty        <= (w_rd_gray_next == wr_ptr_gray_s);
      alm_empty    <= (w_occ_next <= ALM_TH);
      rd_valid     <= w_accept;
      underflow    <= rd_en & empty;
      wrap_B_delay <= w_wrap_B;
    end
  end

`ifdef RD_LEVEL_EN
  always_ff @(posedge clk_r) begin
    if (rst_r) begin
      rd_level <= '0;
    end else begin
      rd_level <= w_occ_next;
    end
  end
`endif

endmodule

// File: tb/tb_rd_ptr_empty_gen.sv
// Directed testbench for rd_ptr_empty_gen (ADDR_W=4, ALM_EMPTY_TH=2).
module tb_rd_ptr_empty_gen;

  logic       clk_r = 1'b0;
  logic       rst_r;
  logic       rd_en;
  logic [4:0] wr_ptr_gray_s;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr_gray;
  logic       empty;
  logic       alm_empty;
  logic       rd_valid;
  logic       underflow;
  logic       wrap_B_delay;
`ifdef RD_LEVEL_EN
  logic [4:0] rd_level;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_r = ~clk_r;

  rd_ptr_empty_gen #(.ADDR_W(4), .ALM_EMPTY_TH(2)) dut (
    .clk_r        (clk_r),
    .rst_r        (rst_r),
    .rd_en        (rd_en),
    .wr_ptr_gray_s(wr_ptr_gray_s),
    .rd_addr      (rd_addr),
    .rd_ptr_gray  (rd_ptr_gray),
    .empty        (empty),
    .alm_empty    (alm_empty),
    .rd_valid     (rd_valid),
    .underflow    (underflow),
    .wrap_B_delay (wrap_B_delay)
`ifdef RD_LEVEL_EN
    ,
    .rd_level     (rd_level)
`endif
  );

  function automatic logic [4:0] gray5(input int unsigned v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk_r);
    #1;
  endtask

  task automatic do_reset();
    rst_r = 1'b1;
    rd_en = 1'b0;
    tick();
    rst_r = 1'b0;
  endtask

  task automatic test_reset();
    rst_r = 1'b1;
    rd_en = 1'b1;
    wr_ptr_gray_s = 5'b00010;
    tick();
    tick();
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
    n_checks++; if (alm_empty !== 1'b1) $display("FAIL reset_alm_empty got %b want 1", alm_empty); else n_pass++;
    n_checks++; if (rd_ptr_gray !== 5'b00000) $display("FAIL reset_gray got %b want 00000", rd_ptr_gray); else n_pass++;
    n_checks++; if (rd_addr !== 4'd0) $display("FAIL reset_addr got %0d want 0", rd_addr); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rd_valid); else n_pass++;
    n_checks++; if (underflow !== 1'b0) $display("FAIL reset_underflow got %b want 0", underflow); else n_pass++;
    n_checks++; if (wrap_B_delay !== 1'b0) $display("FAIL reset_wrap got %b want 0", wrap_B_delay); else n_pass++;
`ifdef RD_LEVEL_EN
    n_checks++; if (rd_level !== 5'd0) $display("FAIL reset_level got %0d want 0", rd_level); else n_pass++;
`endif
    rst_r = 1'b0;
    rd_en = 1'b0;
    wr_ptr_gray_s = 5'b00000;
    tick();
    n_checks++; if (empty !== 1'b1) $display("FAIL post_reset_empty got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_drain();
    wr_ptr_gray_s = 5'b00010;
    rd_en = 1'b0;
    tick();
    n_checks++; if (empty !== 1'b0) $display("FAIL drain_empty0 got %b want 0", empty); else n_pass++;
    n_checks++; if (alm_empty !== 1'b0) $display("FAIL drain_alm0 got %b want 0", alm_empty); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL drain_valid0 got %b want 0", rd_valid); else n_pass++;
    rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (rd_addr !== 4'(i)) $display("FAIL drain_addr%0d got %0d want %0d", i, rd_addr, i); else n_pass++;
      n_checks++; if (rd_valid !== 1'b1) $display("FAIL drain_valid%0d got %b want 1", i, rd_valid); else n_pass++;
      n_checks++; if (alm_empty !== 1'b1) $display("FAIL drain_alm%0d got %b want 1", i, alm_empty); else n_pass++;
      n_checks++; if (empty !== (i == 3)) $display("FAIL drain_empty%0d got %b want %b", i, empty, (i == 3)); else n_pass++;
    end
    n_checks++; if (rd_ptr_gray !== 5'b00010) $display("FAIL drain_gray got %b want 00010", rd_ptr_gray); else n_pass++;
    rd_en = 1'b0;
    tick();
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL drain_valid_end got %b want 0", rd_valid); else n_pass++;
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    tick();
    n_checks++; if (underflow !== 1'b1) $display("FAIL uf_pulse got %b want 1", underflow); else n_pass++;
    n_checks++; if (rd_addr !== 4'd3) $display("FAIL uf_addr got %0d want 3", rd_addr); else n_pass++;
    n_checks++; if (rd_ptr_gray !== 5'b00010) $display("FAIL uf_gray got %b want 00010", rd_ptr_gray); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL uf_valid got %b want 0", rd_valid); else n_pass++;
    rd_en = 1'b0;
    tick();
    n_checks++; if (underflow !== 1'b0) $display("FAIL uf_clear got %b want 0", underflow); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL uf_empty got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    wr_ptr_gray_s = 5'b11110;
    tick();
    n_checks++; if (empty !== 1'b0) $display("FAIL wrap_pre_empty got %b want 0", empty); else n_pass++;
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_checks++; if (rd_addr !== 4'(i % 16)) $display("FAIL wrap_addr%0d got %0d want %0d", i, rd_addr, i % 16); else n_pass++;
      n_checks++; if (wrap_B_delay !== (i == 16)) $display("FAIL wrap_pulse%0d got %b want %b", i, wrap_B_delay, (i == 16)); else n_pass++;
    end
    n_checks++; if (rd_ptr_gray !== 5'b11000) $display("FAIL wrap_gray got %b want 11000", rd_ptr_gray); else n_pass++;
    n_checks++; if (empty !== 1'b0) $display("FAIL wrap_empty got %b want 0", empty); else n_pass++;
    n_checks++; if (alm_empty !== 1'b0) $display("FAIL wrap_alm got %b want 0", alm_empty); else n_pass++;
`ifdef RD_LEVEL_EN
    n_checks++; if (rd_level !== 5'd4) $display("FAIL wrap_level got %0d want 4", rd_level); else n_pass++;
`endif
    rd_en = 1'b0;
    tick();
    n_checks++; if (wrap_B_delay !== 1'b0) $display("FAIL wrap_pulse_end got %b want 0", wrap_B_delay); else n_pass++;
    n_checks++; if (rd_addr !== 4'd0) $display("FAIL wrap_addr_hold got %0d want 0", rd_addr); else n_pass++;
  endtask

  task automatic test_full_span();
    do_reset();
    wr_ptr_gray_s = 5'b11000;
    tick();
    n_checks++; if (empty !== 1'b0) $display("FAIL full_empty got %b want 0", empty); else n_pass++;
    n_checks++; if (alm_empty !== 1'b0) $display("FAIL full_alm got %b want 0", alm_empty); else n_pass++;
`ifdef RD_LEVEL_EN
    n_checks++; if (rd_level !== 5'd16) $display("FAIL full_level got %0d want 16", rd_level); else n_pass++;
`endif
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_checks++; if (empty !== (i == 16)) $display("FAIL full_empty%0d got %b want %b", i, empty, (i == 16)); else n_pass++;
      n_checks++; if (rd_ptr_gray !== gray5(i)) $display("FAIL full_gray%0d got %b want %b", i, rd_ptr_gray, gray5(i)); else n_pass++;
      n_checks++; if (alm_empty !== (i >= 14)) $display("FAIL full_alm%0d got %b want %b", i, alm_empty, (i >= 14)); else n_pass++;
    end
    tick();
    n_checks++; if (underflow !== 1'b1) $display("FAIL full_uf got %b want 1", underflow); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL full_uf_valid got %b want 0", rd_valid); else n_pass++;
    n_checks++; if (rd_ptr_gray !== 5'b11000) $display("FAIL full_uf_gray got %b want 11000", rd_ptr_gray); else n_pass++;
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_ptr_gray_s = 5'b00010;
    tick();
    rd_en = 1'b1;
    tick();
    n_checks++; if (rd_addr !== 4'd1) $display("FAIL mid_addr1 got %0d want 1", rd_addr); else n_pass++;
    n_checks++; if (rd_valid !== 1'b1) $display("FAIL mid_valid1 got %b want 1", rd_valid); else n_pass++;
    rst_r = 1'b1;
    tick();
    n_checks++; if (rd_addr !== 4'd0) $display("FAIL mid_rst_addr got %0d want 0", rd_addr); else n_pass++;
    n_checks++; if (rd_ptr_gray !== 5'b00000) $display("FAIL mid_rst_gray got %b want 00000", rd_ptr_gray); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", rd_valid); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL mid_rst_empty got %b want 1", empty); else n_pass++;
    n_checks++; if (alm_empty !== 1'b1) $display("FAIL mid_rst_alm got %b want 1", alm_empty); else n_pass++;
    n_checks++; if (underflow !== 1'b0) $display("FAIL mid_rst_uf got %b want 0", underflow); else n_pass++;
    rst_r = 1'b0;
    rd_en = 1'b0;
    tick();
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL mid_post_valid got %b want 0", rd_valid); else n_pass++;
    n_checks++; if (empty !== 1'b0) $display("FAIL mid_post_empty got %b want 0", empty); else n_pass++;
    n_checks++; if (alm_empty !== 1'b0) $display("FAIL mid_post_alm got %b want 0", alm_empty); else n_pass++;
  endtask

  initial begin
    rst_r = 1'b1;
    rd_en = 1'b0;
    wr_ptr_gray_s = 5'b00000;
    test_reset();
    test_drain();
    test_underflow();
    test_wrap();
    test_full_span();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
